// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, CSR addresses and mstatus bit positions for the trap sequencer.
package trap_pkg;
    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_TVAL,
        UPD_STATUS,
        RST_STATUS,
        REDIRECT
    } state_e;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_HI = 12;
    localparam int MPP_LO = 11;
    localparam logic [31:0] EXC_ILLEGAL = 32'd2;
endpackage

// File: rtl/mstatus_xform.sv
// mstatus_xform: mstatus update for trap entry (exit_i=0) or MRET (exit_i=1).
module mstatus_xform
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mstatus_i,
    input  logic            exit_i,
    output logic [XLEN-1:0] mstatus_o
);
    always_comb begin
        mstatus_o = mstatus_i;
        mstatus_o[MIE] = exit_i ? mstatus_i[MPIE] : 1'b0;
        mstatus_o[MPIE] = exit_i ? 1'b1 : mstatus_i[MIE];
        mstatus_o[MPP_HI:MPP_LO] = 2'b11;
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap entry / MRET sequencer that owns the CSR write port and stalls the core.
// Define TRAP_MTVAL_EN to add the mtval write (SAVE_TVAL) to the trap path.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_enter,
    input  logic              trap_exit,
    input  logic [XLEN-1:0]   exception_code,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    input  logic              ins_csr_we,
    input  logic [CSR_AW-1:0] ins_csr_addr,
    input  logic [XLEN-1:0]   ins_csr_wdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              stall,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              busy
);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
    state_e state_q, state_d;
    logic exit_q, exit_d;
    logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, status_new;
`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] instr_q, instr_d;
`else
    logic unused_instr;
    assign unused_instr = ^instr_i;
`endif

    mstatus_xform #(.XLEN(XLEN)) u_xform (
        .mstatus_i(mstatus_i),
        .exit_i   (state_q == RST_STATUS),
        .mstatus_o(status_new)
    );

    assign busy  = state_q != IDLE;
    assign stall = trap_enter | trap_exit | busy;

    always_comb begin
        state_d = state_q;
        exit_d = exit_q;
        pc_d = pc_q;
        cause_d = cause_q;
`ifdef TRAP_MTVAL_EN
        instr_d = instr_q;
`endif
        csr_we = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        case (state_q)
            IDLE: begin
                // the request cycle's own CSR write belongs to the trapping instruction and is dropped
                csr_we = ins_csr_we & ~trap_enter & ~trap_exit;
                csr_waddr = ins_csr_addr;
                csr_wdata = ins_csr_wdata;
                if (trap_enter) begin
                    state_d = SAVE_EPC;
                    exit_d = 1'b0;
                    pc_d = pc_i;
                    cause_d = exception_code;
`ifdef TRAP_MTVAL_EN
                    instr_d = instr_i;
`endif
                end else if (trap_exit) begin
                    state_d = RST_STATUS;
                    exit_d = 1'b1;
                end
            end
            SAVE_EPC: begin
                csr_we = 1'b1;
                csr_waddr = CSR_AW'(CSR_MEPC);
                csr_wdata = pc_q & ALIGN;
                state_d = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we = 1'b1;
                csr_waddr = CSR_AW'(CSR_MCAUSE);
                csr_wdata = cause_q;
`ifdef TRAP_MTVAL_EN
                state_d = SAVE_TVAL;
`else
                state_d = UPD_STATUS;
`endif
            end
`ifdef TRAP_MTVAL_EN
            SAVE_TVAL: begin
                csr_we = 1'b1;
                csr_waddr = CSR_AW'(CSR_MTVAL);
                csr_wdata = instr_q;
                state_d = UPD_STATUS;
            end
`endif
            UPD_STATUS, RST_STATUS: begin
                csr_we = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = status_new;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc = (exit_q ? mepc_i : mtvec_i) & ALIGN;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            exit_q <= 1'b0;
            pc_q <= '0;
            cause_q <= '0;
`ifdef TRAP_MTVAL_EN
            instr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            exit_q <= exit_d;
            pc_q <= pc_d;
            cause_q <= cause_d;
`ifdef TRAP_MTVAL_EN
            instr_q <= instr_d;
`endif
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized checks of trap_sequencer against a write-schedule model.
module tb_trap_sequencer;
    logic clk = 1'b0;
    logic rst, trap_enter, trap_exit, ins_csr_we;
    logic [31:0] exception_code, pc_i, instr_i, ins_csr_wdata;
    logic [11:0] ins_csr_addr;
    logic csr_we, stall, redirect_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [31:0] mstatus = 32'h0, mtvec = 32'h0, mepc = 32'h0;
    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    typedef enum {OP_EPC, OP_CAUSE, OP_TVAL, OP_ENTER, OP_EXIT, OP_RTVEC, OP_REPC} op_t;
    op_t ops[$];
    logic [31:0] m_pc, m_cause, m_instr;

    trap_sequencer dut (
        .clk(clk), .rst(rst), .trap_enter(trap_enter), .trap_exit(trap_exit),
        .exception_code(exception_code), .pc_i(pc_i), .instr_i(instr_i),
        .mstatus_i(mstatus), .mtvec_i(mtvec), .mepc_i(mepc),
        .ins_csr_we(ins_csr_we), .ins_csr_addr(ins_csr_addr), .ins_csr_wdata(ins_csr_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // minimal CSR file fed by the arbitrated write port
    always @(posedge clk) begin
        if (csr_we) begin
            if (csr_waddr == 12'h300) mstatus <= csr_wdata;
            if (csr_waddr == 12'h305) mtvec <= csr_wdata;
            if (csr_waddr == 12'h341) mepc <= csr_wdata;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_we, e_rv, e_busy, e_stall;
            logic [31:0] e_addr, e_data, e_rpc;
            e_we = 0; e_rv = 0; e_addr = 0; e_data = 0; e_rpc = 0;
            e_busy = ops.size() != 0;
            e_stall = e_busy | trap_enter | trap_exit;
            if (!e_busy) begin
                e_we = ins_csr_we & !trap_enter & !trap_exit;
                e_addr = {20'h0, ins_csr_addr};
                e_data = ins_csr_wdata;
            end else begin
                e_we = 1;
                case (ops[0])
                    OP_EPC:   begin e_addr = 32'h341; e_data = {m_pc[31:2], 2'b00}; end
                    OP_CAUSE: begin e_addr = 32'h342; e_data = m_cause; end
                    OP_TVAL:  begin e_addr = 32'h343; e_data = m_instr; end
                    OP_ENTER: begin e_addr = 32'h300;
                        e_data = (mstatus & ~32'h1888) | (((mstatus >> 3) & 1) << 7) | 32'h1800; end
                    OP_EXIT:  begin e_addr = 32'h300;
                        e_data = (mstatus & ~32'h1888) | (((mstatus >> 7) & 1) << 3) | 32'h1880; end
                    OP_RTVEC: begin e_we = 0; e_rv = 1; e_rpc = mtvec & ~32'h3; end
                    default:  begin e_we = 0; e_rv = 1; e_rpc = mepc & ~32'h3; end
                endcase
            end
            chk("model_csr_we", {31'h0, csr_we}, {31'h0, e_we});
            if (e_we) begin
                chk("model_csr_waddr", {20'h0, csr_waddr}, e_addr);
                chk("model_csr_wdata", csr_wdata, e_data);
            end
            chk("model_redirect_valid", {31'h0, redirect_valid}, {31'h0, e_rv});
            chk("model_redirect_pc", redirect_pc, e_rpc);
            chk("model_busy", {31'h0, busy}, {31'h0, e_busy});
            chk("model_stall", {31'h0, stall}, {31'h0, e_stall});
            if (rst) ops.delete();
            else if (ops.size() != 0) void'(ops.pop_front());
            else if (trap_enter) begin
                m_pc = pc_i; m_cause = exception_code; m_instr = instr_i;
                ops.push_back(OP_EPC); ops.push_back(OP_CAUSE);
`ifdef TRAP_MTVAL_EN
                ops.push_back(OP_TVAL);
`endif
                ops.push_back(OP_ENTER); ops.push_back(OP_RTVEC);
            end else if (trap_exit) begin
                ops.push_back(OP_EXIT); ops.push_back(OP_REPC);
            end
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic look(); @(negedge clk); endtask
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        ins_csr_we = 1; ins_csr_addr = a; ins_csr_wdata = d;
    endtask

    initial begin
        rst = 1; trap_enter = 0; trap_exit = 0; ins_csr_we = 0; ins_csr_addr = 0; ins_csr_wdata = 0;
        exception_code = 0; pc_i = 0; instr_i = 0;
        step(); chk_en = 1; step();
        look();
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_csr_we", {31'h0, csr_we}, 32'h0);
        chk("reset_redirect", {31'h0, redirect_valid}, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        step(); rst = 0; wr(12'h300, 32'h8);
        step(); wr(12'h305, 32'h400);
        look();
        chk("pass_we", {31'h0, csr_we}, 32'h1);
        chk("pass_addr", {20'h0, csr_waddr}, 32'h305);
        chk("pass_data", csr_wdata, 32'h400);
        step(); wr(12'h305, 32'h201);
        // trap entry with a coincident CSR instruction write
        step(); wr(12'h305, 32'h400); trap_enter = 1; pc_i = 32'h104; exception_code = 32'h2; instr_i = 0;
        look();
        chk("trap_req_we", {31'h0, csr_we}, 32'h0);
        chk("trap_req_stall", {31'h0, stall}, 32'h1);
        step(); trap_enter = 0;
        look();
        chk("trap_epc_addr", {20'h0, csr_waddr}, 32'h341);
        chk("trap_epc_data", csr_wdata, 32'h104);
        step(); ins_csr_we = 0;
        look();
        chk("trap_cause_addr", {20'h0, csr_waddr}, 32'h342);
        chk("trap_cause_data", csr_wdata, 32'h2);
`ifdef TRAP_MTVAL_EN
        step(); look();
        chk("trap_tval_addr", {20'h0, csr_waddr}, 32'h343);
        chk("trap_tval_data", csr_wdata, 32'h0);
`endif
        step(); look();
        chk("trap_status_addr", {20'h0, csr_waddr}, 32'h300);
        chk("trap_status_data", csr_wdata, 32'h1880);
        chk("trap_status_stall", {31'h0, stall}, 32'h1);
        step(); look();
        chk("trap_redirect_valid", {31'h0, redirect_valid}, 32'h1);
        chk("trap_redirect_pc", redirect_pc, 32'h200);
        chk("trap_redirect_stall", {31'h0, stall}, 32'h1);
        step(); wr(12'h341, 32'h108);
        look();
        chk("trap_done_busy", {31'h0, busy}, 32'h0);
        // MRET
        step(); ins_csr_we = 0; trap_exit = 1;
        look();
        chk("mret_req_we", {31'h0, csr_we}, 32'h0);
        step(); trap_exit = 0;
        look();
        chk("mret_status_data", csr_wdata, 32'h1888);
        chk("mret_busy", {31'h0, busy}, 32'h1);
        step(); look();
        chk("mret_redirect_pc", redirect_pc, 32'h108);
        step(); look();
        chk("mret_done_busy", {31'h0, busy}, 32'h0);
        // simultaneous enter and exit
        step(); trap_enter = 1; trap_exit = 1; pc_i = 32'h200;
        step(); trap_enter = 0; trap_exit = 0;
        look();
        chk("both_first_addr", {20'h0, csr_waddr}, 32'h341);
        repeat (6) step();
        // reset during SAVE_CAUSE
        trap_enter = 1; pc_i = 32'h300; exception_code = 32'h2;
        step(); trap_enter = 0;
        step(); rst = 1;
        look();
        chk("abort_cause_addr", {20'h0, csr_waddr}, 32'h342);
        step(); rst = 0;
        look();
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_we", {31'h0, csr_we}, 32'h0);
        repeat (4) begin
            step(); look();
            chk("abort_no_redirect", {31'h0, redirect_valid}, 32'h0);
        end
        // randomized traffic
        repeat (3000) begin
            step();
            rst = $urandom_range(63) == 0;
            trap_enter = $urandom_range(7) == 0;
            trap_exit = $urandom_range(7) == 0;
            ins_csr_we = $urandom_range(1) == 1;
            case ($urandom_range(4))
                0: ins_csr_addr = 12'h300;
                1: ins_csr_addr = 12'h305;
                2: ins_csr_addr = 12'h341;
                3: ins_csr_addr = 12'h342;
                default: ins_csr_addr = 12'h7c0;
            endcase
            ins_csr_wdata = $urandom;
            pc_i = $urandom; exception_code = $urandom_range(15); instr_i = $urandom;
        end
        step(); rst = 0; trap_enter = 0; trap_exit = 0; ins_csr_we = 0;
        repeat (8) step();
        look();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that sequences machine-mode trap entry (illegal instruction) and MRET exit for the RV32IM single-cycle core.
- Owns and arbitrates the CSR file's single write port between the executing CSR instruction and its own trap writes.
- Stalls the pipeline/PC while it runs, then issues a one-cycle PC redirect.
- Sits between the control unit (trap_enter, trap_exit, exception_code) and the CSR file / PC register.

Parameters:
- XLEN, 32, datapath and CSR data width.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- trap_enter  in  1  illegal-instruction trap request from control unit
- trap_exit  in  1  MRET decoded
- exception_code  in  XLEN  mcause value
- pc_i  in  XLEN  PC of current instruction
- instr_i  in  XLEN  current instruction word
- mstatus_i  in  XLEN  current mstatus read from CSR file
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- ins_csr_we  in  1  CSR instruction write request
- ins_csr_addr  in  CSR_AW  CSR instruction write address
- ins_csr_wdata  in  XLEN  CSR instruction write data
- csr_we  out  1  arbitrated CSR write enable
- csr_waddr  out  CSR_AW  arbitrated CSR write address
- csr_wdata  out  XLEN  arbitrated CSR write data
- stall  out  1  freeze PC/regfile/memory writes
- redirect_valid  out  1  one-cycle PC load strobe
- redirect_pc  out  XLEN  PC load target
- busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high: at the clk edge with rst=1, state <= IDLE and latched pc/cause/instr <= 0.
- Reset values of outputs: csr_we=0, csr_waddr=0, csr_wdata=0, redirect_valid=0, redirect_pc=0, busy=0. stall=0 unless trap_enter/trap_exit are high.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL (feature only), UPD_STATUS, RST_STATUS, REDIRECT.
- IDLE, trap_enter=1: latch pc_i, exception_code, instr_i; go to SAVE_EPC. The same-cycle ins_csr_we is suppressed (the faulting instruction does not commit).
- IDLE, trap_exit=1 (and trap_enter=0): go to RST_STATUS. The same-cycle ins_csr_we is suppressed.
- trap_enter and trap_exit both high: trap_enter wins.
- IDLE, otherwise: csr_* is a combinational pass-through of ins_csr_*.
- Trap path, one CSR write per state:
  - SAVE_EPC: addr 0x341, data = latched pc with bits[1:0]=0.
  - SAVE_CAUSE: addr 0x342, data = latched cause.
  - UPD_STATUS: addr 0x300, data = mstatus_i with MPIE(7)=MIE(3), MIE=0, MPP[12:11]=2'b11.
  - REDIRECT: redirect_valid=1, redirect_pc = {mtvec_i[31:2],2'b00}; then IDLE.
- Exit path:
  - RST_STATUS: addr 0x300, data = mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
  - REDIRECT: redirect_pc = {mepc_i[31:2],2'b00}.
- mstatus_i, mtvec_i and mepc_i are sampled in the state that uses them. They must reflect writes committed in earlier states (the CSR file writes on the clk edge).
- Outputs in non-IDLE states are decoded from the state register only. ins_csr_* are ignored there.
- stall = trap_enter | trap_exit | busy. REDIRECT keeps stall=1; the PC loads redirect_pc at the end of that cycle.
- Latency: trap takes 4 non-IDLE cycles (5 with the feature); MRET takes 2. The first fetch at the target occurs on the cycle after REDIRECT.
- trap_enter/trap_exit while busy: ignored, no queuing.
- rst mid-sequence: abort next edge. No further CSR writes, no redirect. Partially written CSRs are left as is.

Optional Feature:
- TRAP_MTVAL_EN defined: SAVE_TVAL is inserted between SAVE_CAUSE and UPD_STATUS. It writes addr 0x343, data = latched instruction word. Trap latency becomes 5 cycles.
- Undefined: SAVE_TVAL and its instruction latch are absent; the mtval CSR is never written by this block.

Decomposition:
- Shared package trap_pkg holds:
  - state enum;
  - CSR address constants CSR_MSTATUS=0x300, CSR_MTVEC=0x305, CSR_MEPC=0x341, CSR_MCAUSE=0x342, CSR_MTVAL=0x343;
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11;
  - EXC_ILLEGAL=2.
- One natural sub-module: mstatus_xform, purely combinational. Input mstatus and an enter/exit select; output the updated mstatus. It is reused by UPD_STATUS and RST_STATUS.

Test Plan:
- Trap entry, no feature: pc_i=0x0000_0104, code=2, mstatus_i=0x8 (MIE=1), mtvec_i=0x0000_0201. Pulse trap_enter. Expect:
  - writes (0x341,0x104), (0x342,0x2), (0x300,0x1880) on consecutive cycles;
  - then redirect_valid=1, redirect_pc=0x200;
  - stall high 5 cycles including the request cycle.
- MRET: mstatus_i=0x1880, mepc_i=0x108. Pulse trap_exit. Expect write (0x300,0x1888), then redirect_pc=0x108, busy for 2 cycles.
- Arbitration: ins_csr_we=1 addr 0x305 data 0x400 in IDLE -> pass-through same cycle. The same request coincident with trap_enter -> csr_we=0 that cycle. Requests during busy are never forwarded.
- Simultaneous trap_enter and trap_exit -> trap path taken (first write addr 0x341).
- rst=1 during SAVE_CAUSE -> next cycle busy=0, csr_we=0, redirect_valid never asserts.
- TRAP_MTVAL_EN defined: instr_i=0x0000_0000 trap -> extra write (0x343,0x0) after mcause. Redirect occurs at cycle 5.
